wide_add_seq: RTL and testbench

Multi-cycle wide-operand adder sequencer. It accepts one P_NUM_SLICES×P_SLICE_W-bit addition through a valid/ready handshake and runs it over a single P_SLICE_W-bit carry-look-ahead slice adder, one slice per cycle, least-significant slice first. The slice carry-out is registered and fed back as the next slice's carry-in. It sits between operand producers and consumers in the adder-comparison datapath, so one CLA slice can serve operands wider than the slice.

---
 rtl/wide_add_pkg.sv | 7 +
 rtl/cla_slice_add.sv | 36 +++
 rtl/wide_add_seq.sv | 93 +++++++++
 tb/tb_wide_add_seq.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/wide_add_pkg.sv
// Shared types and default geometry for the wide-operand adder sequencer.
package wide_add_pkg;
  localparam int SLICE_W_DEF    = 32;
  localparam int NUM_SLICES_DEF = 4;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/cla_slice_add.sv
// Combinational P_SLICE_W-bit carry-look-ahead adder (parallel-prefix carries).
module cla_slice_add #(
  parameter int P_SLICE_W = 32
) (
  input  logic [P_SLICE_W-1:0] a,
  input  logic [P_SLICE_W-1:0] b,
  input  logic                 cin,
  output logic [P_SLICE_W-1:0] sum,
  output logic                 cout
);
  localparam int LV = (P_SLICE_W > 1) ? $clog2(P_SLICE_W) : 0;

  logic [LV:0][P_SLICE_W-1:0] gg, pp;
  logic [P_SLICE_W:0]         c;

  assign gg[0] = a & b;
  assign pp[0] = a ^ b;

  // Level l merges each bit's group with the group 2^l positions below it.
  for (genvar l = 0; l < LV; l++) begin : g_lvl
    for (genvar i = 0; i < P_SLICE_W; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_merge
        assign gg[l+1][i] = gg[l][i] | (pp[l][i] & gg[l][i-(1<<l)]);
        assign pp[l+1][i] = pp[l][i] & pp[l][i-(1<<l)];
      end else begin : g_pass
        assign gg[l+1][i] = gg[l][i];
        assign pp[l+1][i] = pp[l][i];
      end
    end
  end

  assign c[0]           = cin;
  assign c[P_SLICE_W:1] = gg[LV] | (pp[LV] & {P_SLICE_W{cin}});
  assign sum            = pp[0] ^ c[P_SLICE_W-1:0];
  assign cout           = c[P_SLICE_W];
endmodule

// File: rtl/wide_add_seq.sv
// Multi-cycle wide adder: one shared CLA slice, LS slice first, registered carry chain.
// Optional subtract mode is enabled by defining WIDE_ADD_SUB_EN.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int P_SLICE_W    = SLICE_W_DEF,
  parameter int P_NUM_SLICES = NUM_SLICES_DEF
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                in_valid_i,
  output logic                                in_ready_o,
  input  logic [P_SLICE_W*P_NUM_SLICES-1:0]   a_i,
  input  logic [P_SLICE_W*P_NUM_SLICES-1:0]   b_i,
  input  logic                                cin_i,
`ifdef WIDE_ADD_SUB_EN
  input  logic                                sub_i,
`endif
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [P_SLICE_W*P_NUM_SLICES-1:0]   sum_o,
  output logic                                cout_o,
  output logic                                busy_o
);
  localparam int W  = P_SLICE_W * P_NUM_SLICES;
  localparam int IW = $clog2((P_NUM_SLICES > 1) ? P_NUM_SLICES : 2);
  localparam logic [IW-1:0] LAST = IW'(P_NUM_SLICES - 1);

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic [W-1:0]    a_r, b_r, sum_r;
  logic            carry;
  logic [P_SLICE_W-1:0] sl_sum;
  logic            sl_cout;

  cla_slice_add #(.P_SLICE_W(P_SLICE_W)) u_slice (
    .a    (a_r[int'(idx)*P_SLICE_W +: P_SLICE_W]),
    .b    (b_r[int'(idx)*P_SLICE_W +: P_SLICE_W]),
    .cin  (carry),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid_i)    state_nxt = RUN;
      RUN:     if (idx == LAST)   state_nxt = DONE;
      DONE:    if (out_ready_i)   state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      sum_r <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid_i) begin
          a_r <= a_i;
          idx <= '0;
`ifdef WIDE_ADD_SUB_EN
          // Two's-complement subtract: invert B and inject +1 as the initial carry.
          b_r   <= sub_i ? ~b_i : b_i;
          carry <= sub_i ? 1'b1 : cin_i;
`else
          b_r   <= b_i;
          carry <= cin_i;
`endif
        end
        RUN: begin
          sum_r[int'(idx)*P_SLICE_W +: P_SLICE_W] <= sl_sum;
          carry <= sl_cout;
          if (idx != LAST) idx <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  // After the last slice the carry register holds the carry out of bit W-1.
  assign sum_o       = sum_r;
  assign cout_o      = carry;
  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);
  assign busy_o      = (state != IDLE);
endmodule

// File: tb/tb_wide_add_seq.sv
// Directed self-checking bench for wide_add_seq (default 4 x 32-bit slices).
module tb_wide_add_seq;
  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [127:0] a_i, b_i;
  logic         cin_i;
`ifdef WIDE_ADD_SUB_EN
  logic         sub_i;
`endif
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] sum_o;
  logic         cout_o;
  logic         busy_o;

  int checks = 0;
  int errors = 0;

  wide_add_seq dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .cin_i       (cin_i),
`ifdef WIDE_ADD_SUB_EN
    .sub_i       (sub_i),
`endif
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .sum_o       (sum_o),
    .cout_o      (cout_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  128'(in_ready_o),  128'd1);
    chk({tag, "_out_valid"}, 128'(out_valid_o), 128'd0);
    chk({tag, "_busy"},      128'(busy_o),      128'd0);
  endtask

  // Accept one op, scramble the inputs, wait for DONE, check result, drain it.
  task automatic do_op(input string tag, input logic [127:0] a, input logic [127:0] b,
                       input logic c, input logic s,
                       input logic [127:0] exp_sum, input logic exp_cout);
    int n;
    a_i = a; b_i = b; cin_i = c;
`ifdef WIDE_ADD_SUB_EN
    sub_i = s;
`endif
    in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    a_i = {4{32'hDEAD_BEEF}}; b_i = {4{32'h1234_5678}}; cin_i = ~c;
`ifdef WIDE_ADD_SUB_EN
    sub_i = ~s;
`endif
    chk({tag, "_busy"},     128'(busy_o),     128'd1);
    chk({tag, "_in_ready"}, 128'(in_ready_o), 128'd0);
    n = 0;
    do begin
      step();
      n++;
    end while (!out_valid_o && n < 20);
    chk({tag, "_latency"}, 128'(n),      128'd4);
    chk({tag, "_sum"},     sum_o,        exp_sum);
    chk({tag, "_cout"},    128'(cout_o), 128'(exp_cout));
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    chk_idle({tag, "_drain"});
  endtask

  initial begin
    logic seen;
    rst_i = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b0;
    a_i = '0; b_i = '0; cin_i = 1'b0;
`ifdef WIDE_ADD_SUB_EN
    sub_i = 1'b0;
`endif
    step(); step();
    rst_i = 1'b0;
    chk_idle("reset");
    chk("reset_sum",  sum_o,         128'd0);
    chk("reset_cout", 128'(cout_o),  128'd0);

    do_op("ripple", {128{1'b1}}, 128'd1, 1'b0, 1'b0, 128'd0, 1'b1);

    do_op("boundary", 128'h0000_0000_FFFF_FFFF_0000_0000_FFFF_FFFF, 128'd1, 1'b1, 1'b0,
          128'h0000_0000_FFFF_FFFF_0000_0001_0000_0001, 1'b0);

    // Backpressure in DONE with a competing request held high.
    a_i = 128'h10; b_i = 128'h20; cin_i = 1'b1; in_valid_i = 1'b1;
    step();
    a_i = 128'd100; b_i = 128'd200; cin_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("bp_enter_done", 128'(out_valid_o), 128'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_sum",      sum_o,             128'h31);
      chk("bp_cout",     128'(cout_o),      128'd0);
      chk("bp_in_ready", 128'(in_ready_o),  128'd0);
      chk("bp_valid",    128'(out_valid_o), 128'd1);
    end
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;
    chk_idle("bp_release");
    step();
    in_valid_i = 1'b0;
    chk("bp_reaccept_busy", 128'(busy_o), 128'd1);
    for (int i = 0; i < 4; i++) step();
    chk("bp2_valid", 128'(out_valid_o), 128'd1);
    chk("bp2_sum",   sum_o,             128'd300);
    chk("bp2_cout",  128'(cout_o),      128'd0);
    out_ready_i = 1'b1;
    step();
    out_ready_i = 1'b0;

    // Reset at idx=2: two reset cycles inside RUN discard the op.
    a_i = {128{1'b1}}; b_i = {128{1'b1}}; cin_i = 1'b1; in_valid_i = 1'b1;
    step();
    in_valid_i = 1'b0;
    step(); step();
    rst_i = 1'b1;
    seen = 1'b0;
    step(); seen |= out_valid_o;
    step(); seen |= out_valid_o;
    rst_i = 1'b0;
    chk_idle("midrst");
    chk("midrst_sum",  sum_o,        128'd0);
    chk("midrst_cout", 128'(cout_o), 128'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      seen |= out_valid_o;
    end
    chk("midrst_no_valid", 128'(seen), 128'd0);
    do_op("after_rst", 128'd3, 128'd4, 1'b0, 1'b0, 128'd7, 1'b0);

`ifdef WIDE_ADD_SUB_EN
    do_op("sub_neg", 128'd5, 128'd7, 1'b0, 1'b1, {{127{1'b1}}, 1'b0}, 1'b0);
    do_op("sub_pos", 128'd7, 128'd5, 1'b0, 1'b1, 128'd2, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
